// File: rtl/regfile_sb.sv
// Register file with N combinational read ports, async clear and busy scoreboard.
// Optional write-through forwarding: define REGFILE_SB_BYPASS_EN.
module regfile_sb #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4,
  parameter int NREAD   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       regwrite,
  input  logic [REGBITS-1:0]         wa,
  input  logic [WIDTH-1:0]           wd,
  input  logic                       mark_en,
  input  logic [REGBITS-1:0]         mark_addr,
  input  logic [NREAD*REGBITS-1:0]   ra,
  output logic [NREAD*WIDTH-1:0]     rd,
  output logic [NREAD-1:0]           rd_busy,
  output logic [REGBITS:0]           busy_count,
  output logic                       mark_err
);

  localparam int DEPTH = 1 << REGBITS;

  logic [WIDTH-1:0] ram_q [1:DEPTH-1];
  logic [WIDTH-1:0] ram_d [1:DEPTH-1];
  logic [DEPTH-1:1] busy_q, busy_d;
  logic [REGBITS:0] count_q, count_d;
  logic             mark_err_q, mark_err_d;

  logic wr_v, mk_v, same, inc, dec;

  // Qualify events; r0 is never written nor marked
  always_comb begin
    wr_v = regwrite && (wa != '0);
    mk_v = mark_en && (mark_addr != '0);
    same = wr_v && mk_v && (wa == mark_addr);
    inc  = mk_v && !busy_q[mark_addr];
    dec  = wr_v && busy_q[wa] && !same;
  end

  // Next state: write clears busy, a same-cycle mark wins
  always_comb begin
    ram_d  = ram_q;
    busy_d = busy_q;
    if (wr_v) begin
      ram_d[wa]  = wd;
      busy_d[wa] = 1'b0;
    end
    if (mk_v) begin
      busy_d[mark_addr] = 1'b1;
    end
    count_d = count_q
            + {{REGBITS{1'b0}}, inc}
            - {{REGBITS{1'b0}}, dec};
    mark_err_d = mark_err_q
               || (mk_v && busy_q[mark_addr] && !same);
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        ram_q[i] <= '0;
      end
      busy_q     <= '0;
      count_q    <= '0;
      mark_err_q <= 1'b0;
    end else begin
      ram_q      <= ram_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
      mark_err_q <= mark_err_d;
    end
  end

  assign busy_count = count_q;
  assign mark_err   = mark_err_q;

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [REGBITS-1:0] addr;
    logic [WIDTH-1:0]   data;
    logic               bsy;

    assign addr = ra[p*REGBITS +: REGBITS];

    // Combinational read; r0 and reset force zero
    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (rst_n && (addr != '0)) begin
`ifdef REGFILE_SB_BYPASS_EN
        if (regwrite && (wa == addr)) begin
          data = wd;
          bsy  = mark_en && (mark_addr == addr)
              && busy_q[addr];
        end else begin
          data = ram_q[addr];
          bsy  = busy_q[addr];
        end
`else
        data = ram_q[addr];
        bsy  = busy_q[addr];
`endif
      end
    end

    assign rd[p*WIDTH +: WIDTH] = data;
    assign rd_busy[p]           = bsy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: driver pushes predictions, monitor
// pops and compares on the falling edge.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwrite;
  logic [3:0]  wa;
  logic [15:0] wd;
  logic        mark_en;
  logic [3:0]  mark_addr;
  logic [7:0]  ra;
  logic [31:0] rd;
  logic [1:0]  rd_busy;
  logic [4:0]  busy_count;
  logic        mark_err;

  regfile_sb #(.WIDTH(16), .REGBITS(4), .NREAD(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .regwrite(regwrite), .wa(wa), .wd(wd),
    .mark_en(mark_en), .mark_addr(mark_addr),
    .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .busy_count(busy_count), .mark_err(mark_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic [1:0]  rdb;
    logic [4:0]  cnt;
    logic        err;
    logic [15:0] cyc;
  } exp_t;

  exp_t sbq[$];

  logic [15:0] m_mem [16];
  bit          m_bsy [16];
  bit          m_err;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = '0;
      m_bsy[i] = 1'b0;
    end
    m_err = 1'b0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int   c;
    e = '0;
    for (int p = 0; p < 2; p++) begin
      logic [3:0]  a;
      logic [15:0] d;
      logic        b;
      a = ra[p*4 +: 4];
      d = '0;
      b = 1'b0;
      if (rst_n && a != 0) begin
        d = m_mem[a];
        b = m_bsy[a];
`ifdef REGFILE_SB_BYPASS_EN
        if (regwrite && wa == a) begin
          d = wd;
          b = (mark_en && mark_addr == a) ? m_bsy[a] : 1'b0;
        end
`endif
      end
      e.rd[p*16 +: 16] = d;
      e.rdb[p] = b;
    end
    c = 0;
    for (int i = 1; i < 16; i++) c += int'(m_bsy[i]);
    e.cnt = 5'(c);
    e.err = m_err;
    e.cyc = 16'(cyc);
    return e;
  endfunction

  function automatic void model_edge();
    bit wv, mv;
    wv = regwrite && wa != 0;
    mv = mark_en && mark_addr != 0;
    if (mv && m_bsy[mark_addr] && !(wv && wa == mark_addr))
      m_err = 1'b1;
    if (wv) begin
      m_mem[wa] = wd;
      m_bsy[wa] = 1'b0;
    end
    if (mv) m_bsy[mark_addr] = 1'b1;
  endfunction

  function automatic void check(string name, int c,
                                logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
    end
  endfunction

  // Monitor: compare DUT outputs against the oldest prediction
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("rd", int'(e.cyc), rd, e.rd);
      check("rd_busy", int'(e.cyc), 32'(rd_busy), 32'(e.rdb));
      check("busy_count", int'(e.cyc), 32'(busy_count), 32'(e.cnt));
      check("mark_err", int'(e.cyc), 32'(mark_err), 32'(e.err));
    end
  end

  task automatic cycle(input bit rw_i, input logic [3:0] wa_i,
                       input logic [15:0] wd_i, input bit me_i,
                       input logic [3:0] ma_i,
                       input logic [3:0] r0, input logic [3:0] r1);
    regwrite  = rw_i;
    wa        = wa_i;
    wd        = wd_i;
    mark_en   = me_i;
    mark_addr = ma_i;
    ra        = {r1, r0};
    sbq.push_back(predict());
    @(posedge clk);
    if (rst_n) model_edge();
    cyc++;
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r0, input logic [3:0] r1);
    rst_n = 1'b0;
    model_clear();
    cycle(0, 0, 0, 0, 0, r0, r1);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    regwrite = 0; wa = 0; wd = 0;
    mark_en = 0; mark_addr = 0; ra = 0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset(4'd1, 4'd2);

    cycle(1, 5, 16'hBEEF, 0, 0, 5, 0);
    cycle(0, 0, 0, 0, 0, 5, 5);
    do_reset(4'd5, 4'd5);
    cycle(0, 0, 0, 0, 0, 5, 5);

    cycle(1, 0, 16'h1234, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    cycle(0, 0, 0, 1, 3, 3, 7);
    cycle(0, 0, 0, 1, 7, 3, 7);
    cycle(0, 0, 0, 0, 0, 3, 7);
    cycle(1, 3, 16'h00AA, 0, 0, 3, 7);
    cycle(0, 0, 0, 0, 0, 3, 7);

    cycle(0, 0, 0, 1, 4, 4, 0);
    cycle(1, 4, 16'h5555, 1, 4, 4, 4);
    cycle(0, 0, 0, 0, 0, 4, 4);
    cycle(0, 0, 0, 1, 4, 4, 0);
    cycle(0, 0, 0, 0, 0, 4, 0);
    cycle(1, 4, 16'h0001, 0, 0, 4, 0);
    cycle(0, 0, 0, 0, 0, 4, 4);

    cycle(1, 9, 16'h1111, 0, 0, 0, 0);
    cycle(1, 9, 16'hCAFE, 0, 0, 0, 9);
    cycle(0, 0, 0, 0, 0, 0, 9);

    do_reset(4'd0, 4'd0);
    for (int i = 1; i < 16; i++)
      cycle(0, 0, 0, 1, 4'(i), 4'(i), 4'(i - 1));
    cycle(0, 0, 0, 0, 0, 15, 1);
    for (int i = 1; i < 16; i++)
      cycle(1, 4'(i), 16'(i * 257), 0, 0, 4'(i), 4'(16 - i));
    cycle(0, 0, 0, 0, 0, 15, 1);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] w, r0, r1;
      w  = 4'($urandom % 16);
      r0 = 4'($urandom % 16);
      r1 = ($urandom % 4 == 0) ? w : 4'($urandom % 16);
      if (i == 200) do_reset(r0, r1);
      cycle(bit'($urandom % 2), w, 16'($urandom),
            ($urandom % 3 == 0),
            ($urandom % 4 == 0) ? w : 4'($urandom % 16),
            r0, r1);
    end

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    check("drain", cyc, 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
